nf_dm_wait_ctrl: RTL and testbench

//  Data-memory access controller between the CPU data port (addr/we/wd/rd, req/req_ack) and a

---
 rtl/nf_dm_wait_ctrl.sv | 153 +++++++++++++++
 tb/tb_nf_dm_wait_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_dm_wait_ctrl.sv
// ---------------------------------------------------------------------------
// nf_dm_wait_ctrl
//   Data-memory access controller between the CPU data port and a
//   synchronous-read word memory. Each CPU request is captured in IDLE, held
//   for WAIT_CYCLES extra wait states in BUSY, and then completed with a
//   single-cycle acknowledge in ACK. A write produces exactly one memory write
//   strobe, in the first BUSY cycle. Read data is returned in ACK and is then
//   held on rd_dm until the next read completes.
//
// Ports
//   clk         in   1   system clock, rising edge
//   resetn      in   1   synchronous reset, active low
//   addr_dm     in   32  CPU byte address (bits [1:0] and above 2+AW ignored)
//   we_dm       in   1   CPU write enable
//   wd_dm       in   32  CPU write data
//   req_dm      in   1   CPU request, held until req_ack_dm
//   rd_dm       out  32  read data to CPU
//   req_ack_dm  out  1   one-cycle transaction acknowledge
//   addr_mem    out  AW  word address to memory
//   we_mem      out  1   memory write strobe
//   wd_mem      out  32  memory write data
//   rd_mem      in   32  memory read data, valid one cycle after addr_mem
// ---------------------------------------------------------------------------
module nf_dm_wait_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 256,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   addr_dm,
  input  logic          we_dm,
  input  logic [31:0]   wd_dm,
  input  logic          req_dm,
  output logic [31:0]   rd_dm,
  output logic          req_ack_dm,
  output logic [AW-1:0] addr_mem,
  output logic          we_mem,
  output logic [31:0]   wd_mem,
  input  logic [31:0]   rd_mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Wait-state count loaded on capture; the counter is 4 bits wide.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   rd_hold_q, rd_hold_d;

  // Byte-offset bits and bits above the memory range do not select a word;
  // the address therefore wraps modulo DEPTH words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_dm[31:2+AW], addr_dm[1:0]};

  // Next-state logic: capture in IDLE, count down in BUSY, latch read data in ACK.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wd_d      = wd_q;
    rd_hold_d = rd_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (req_dm) begin
          addr_d  = addr_dm[2 +: AW];
          we_d    = we_dm;
          wd_d    = wd_dm;
          cnt_d   = WAIT_INIT;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Writes leave the last read value untouched.
        if (!we_q) begin
          rd_hold_d = rd_mem;
        end else begin
          rd_hold_d = rd_hold_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= {AW{1'b0}};
      we_q      <= 1'b0;
      wd_q      <= 32'd0;
      rd_hold_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  // Output decode; all outputs are forced to zero while resetn is low.
  always_comb begin
    req_ack_dm = 1'b0;
    we_mem     = 1'b0;
    addr_mem   = {AW{1'b0}};
    wd_mem     = 32'd0;
    rd_dm      = 32'd0;
    if (resetn) begin
      addr_mem = addr_q;
      wd_mem   = wd_q;
      // Single strobe: only the first BUSY cycle still has the loaded count.
      we_mem   = (state_q == ST_BUSY) && (cnt_q == WAIT_INIT) && we_q;
      if (state_q == ST_ACK) begin
        req_ack_dm = 1'b1;
        if (!we_q) begin
          rd_dm = rd_mem;
        end else begin
          rd_dm = rd_hold_q;
        end
      end else begin
        req_ack_dm = 1'b0;
        rd_dm      = rd_hold_q;
      end
    end else begin
      req_ack_dm = 1'b0;
    end
  end

endmodule

// File: tb/tb_nf_dm_wait_ctrl.sv
// Self-checking bench for nf_dm_wait_ctrl: a driver issues CPU transactions
// and pushes the expected outcome into a scoreboard; a monitor pops and
// compares whenever the DUT acknowledges.
module tb_nf_dm_wait_ctrl;
  localparam int W     = 2;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   addr_dm, wd_dm, rd_dm, wd_mem, rd_mem;
  logic          we_dm, req_dm, req_ack_dm, we_mem;
  logic [AW-1:0] addr_mem;

  nf_dm_wait_ctrl #(.WAIT_CYCLES(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .addr_dm(addr_dm), .we_dm(we_dm), .wd_dm(wd_dm),
    .req_dm(req_dm), .rd_dm(rd_dm), .req_ack_dm(req_ack_dm), .addr_mem(addr_mem),
    .we_mem(we_mem), .wd_mem(wd_mem), .rd_mem(rd_mem)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h9E3779B1 ^ 32'hA5A5_0F0F;
    if (i == 5) v = 32'hDEADBEEF;
    return v;
  endfunction

  // Environment memory: registered read, write on strobe.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    rd_mem = 32'd0;
    forever begin
      @(posedge clk);
      if (we_mem) mem[addr_mem] <= wd_mem;
      rd_mem <= mem[addr_mem];
    end
  end

  typedef struct {
    bit            is_read;
    logic [31:0]   data;
    logic [AW-1:0] idx;
    int            accept;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
  endtask

  // Monitor: compares on every acknowledge, tracks write strobes and rd_dm hold.
  initial begin : monitor
    logic [31:0]   model_hold;
    int            pulses, pulse_edge;
    logic [AW-1:0] pulse_addr;
    logic [31:0]   pulse_data;
    bit            prev_ack;
    exp_t          e;
    model_hold = 32'd0; pulses = 0; pulse_edge = 0; prev_ack = 1'b0;
    pulse_addr = '0; pulse_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_ack", {31'd0, req_ack_dm}, 32'd0);
        check("rst_we", {31'd0, we_mem}, 32'd0);
        check("rst_rd", rd_dm, 32'd0);
        check("rst_addr", {24'd0, addr_mem}, 32'd0);
        model_hold = 32'd0; pulses = 0; prev_ack = 1'b0;
      end else begin
        if (we_mem) begin
          pulses++; pulse_edge = edges; pulse_addr = addr_mem; pulse_data = wd_mem;
        end
        if (req_ack_dm) begin
          check("ack_twice", {31'd0, prev_ack}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ack: got ack expected none (edge %0d)", edges);
          end else begin
            e = sb.pop_front();
            check("ack_edge", 32'(edges), 32'(e.accept + W + 1));
            check("ack_addr", {24'd0, addr_mem}, {24'd0, e.idx});
            if (e.is_read) begin
              check("rd_data", rd_dm, e.data);
              check("rd_pulses", 32'(pulses), 32'd0);
              model_hold = e.data;
            end else begin
              check("wr_rd_hold", rd_dm, model_hold);
              check("wr_pulses", 32'(pulses), 32'd1);
              check("wr_edge", 32'(pulse_edge), 32'(e.accept));
              check("wr_addr", {24'd0, pulse_addr}, {24'd0, e.idx});
              check("wr_data", pulse_data, e.data);
            end
          end
          pulses = 0;
        end else begin
          check("rd_hold", rd_dm, model_hold);
        end
        prev_ack = req_ack_dm;
      end
    end
  end

  // Waits (bounded) for the acknowledge, then returns #1 after the next edge.
  task automatic wait_ack();
    int n = 0;
    bit seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      if (req_ack_dm) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles (edge %0d)", edges);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Called #1 after a posedge with the DUT idle (or about to be idle).
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    int   idx;
    idx = int'(a[9:2]);
    req_dm = 1'b1; we_dm = we; addr_dm = a; wd_dm = d;
    e.is_read = !we;
    e.idx     = a[9:2];
    e.accept  = edges + 1;
    if (we) begin
      ref_mem[idx] = d;
      e.data = d;
    end else begin
      e.data = ref_mem[idx];
    end
    sb.push_back(e);
    if (!hold) begin
      @(posedge clk); #1;
      // Garbage on the inputs while busy must not affect the transaction.
      req_dm = 1'b0; we_dm = 1'($urandom); addr_dm = $urandom; wd_dm = $urandom;
    end
    wait_ack();
  endtask

  initial begin : driver
    bit          we, hold;
    logic [31:0] a, d;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset with an active write request present.
    resetn = 1'b0; req_dm = 1'b1; we_dm = 1'b1; addr_dm = 32'h14; wd_dm = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; req_dm = 1'b0; we_dm = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Read of preloaded word 5.
    issue(1'b0, 32'h14, 32'd0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Write then read back.
    issue(1'b1, 32'h20, 32'h12345678, 1'b0);
    issue(1'b0, 32'h20, 32'd0, 1'b0);

    // Three back-to-back reads with req held high.
    issue(1'b0, 32'h14, 32'd0, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 1'b1);
    issue(1'b0, 32'h3C, 32'd0, 1'b1);
    req_dm = 1'b0;
    @(posedge clk); #1;

    // Reset for one edge while BUSY with a write whose strobe already fired.
    req_dm = 1'b1; we_dm = 1'b1; addr_dm = 32'h30; wd_dm = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_dm = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    ref_mem[12] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    resetn = 1'b1;
    issue(1'b0, 32'h30, 32'd0, 1'b0);

    // Address wrap to word 0.
    issue(1'b0, 32'h400, 32'd0, 1'b0);
    issue(1'b0, 32'h403, 32'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      we   = 1'($urandom);
      hold = 1'($urandom);
      a    = $urandom;
      d    = $urandom;
      issue(we, a, d, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    req_dm = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
